// File: rtl/decoder_pkg.sv
// decoder_pkg: mode/state encodings and per-bit decode helpers for decoder_scan_param
package decoder_pkg;
  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_THERM  = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SCAN,
    S_HOLD,
    S_DONE
  } state_e;
  // Per-bit forms so callers build vectors of any width 2**N without unused bits
  function automatic logic oh_bit(input int a, input int i);
    return a == i;
  endfunction
  function automatic logic th_bit(input int a, input int i);
    return i <= a;
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: dwell counter; step is high on the cycle the count matches dwell
module scan_timer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          hold,
  input  logic [DW-1:0] dwell,
  output logic          step
);
  logic [DW-1:0] cnt;
  assign step = cnt == dwell;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (!hold) cnt <= step ? '0 : cnt + 1'b1;
endmodule

// File: rtl/decoder_scan_param.sv
// decoder_scan_param: registered N-to-2^N one-hot/thermometer decoder with auto-scan and hold
module decoder_scan_param
  import decoder_pkg::*;
#(
  parameter int N       = 2,
  parameter int DW      = 8,
  parameter int ONESHOT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    a,
  input  logic [DW-1:0]   dwell,
  output logic [2**N-1:0] y,
  output logic            valid,
  output logic            wrap
);
  localparam int OUT_W = 2**N;
  state_e state, state_d;
  logic [N-1:0] idx, idx_d, idx_inc;
  logic [OUT_W-1:0] y_d, oh_a, th_a, oh_inc;
  logic valid_d, wrap_d, resume, resume_d, t_clr, t_hold, step;
  assign idx_inc = idx + 1'b1;
  scan_timer #(.DW(DW)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(t_clr), .hold(t_hold), .dwell(dwell), .step(step)
  );
  always_comb
    for (int i = 0; i < OUT_W; i++) begin
      oh_a[i]   = oh_bit(32'(a), i);
      th_a[i]   = th_bit(32'(a), i);
      oh_inc[i] = oh_bit(32'(idx_inc), i);
    end
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    y_d      = y;
    valid_d  = valid;
    wrap_d   = 1'b0;
    resume_d = 1'b0;
    t_clr    = 1'b1;
    t_hold   = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      y_d     = '0;
      valid_d = 1'b0;
    end else begin
      unique case (mode_e'(mode))
        MODE_ONEHOT: begin
          state_d = S_DECODE;
          y_d     = oh_a;
          valid_d = 1'b1;
        end
        MODE_THERM: begin
          state_d = S_DECODE;
          y_d     = th_a;
          valid_d = 1'b1;
        end
        MODE_HOLD: begin
          state_d  = S_HOLD;
          t_clr    = 1'b0;
          t_hold   = 1'b1;
          resume_d = state == S_SCAN || (state == S_HOLD && resume);
        end
        MODE_SCAN: begin
          // A resumed scan continues counting on the same edge it leaves HOLD
          if (state == S_SCAN || (state == S_HOLD && resume)) begin
            state_d = S_SCAN;
            t_clr   = 1'b0;
            if (step) begin
              idx_d  = idx_inc;
              wrap_d = &idx;
              if (&idx && ONESHOT != 0) begin
                state_d = S_DONE;
                y_d     = '0;
                valid_d = 1'b0;
              end else y_d = oh_inc;
            end
          end else if (state == S_DONE) begin
            y_d     = '0;
            valid_d = 1'b0;
          end else begin
            state_d = S_SCAN;
            idx_d   = a;
            y_d     = oh_a;
            valid_d = 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      y      <= '0;
      valid  <= 1'b0;
      wrap   <= 1'b0;
      resume <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      y      <= y_d;
      valid  <= valid_d;
      wrap   <= wrap_d;
      resume <= resume_d;
    end
endmodule

// File: tb/tb_decoder_scan_param.sv
// tb_decoder_scan_param: table-driven and directed checks of decoder_scan_param
module tb_decoder_scan_param;
  import decoder_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0;
  logic [1:0] mode = 2'd0, a2 = 2'd0;
  logic [2:0] a3 = 3'd0;
  logic [7:0] dwell = 8'd0;
  logic [3:0] y2, yo;
  logic [7:0] y3;
  logic v2, w2, v3, w3, vo, wo;
  int checks = 0, errors = 0;
  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [1:0] a;
    logic [7:0] dwell;
    logic [3:0] y;
    logic       v;
    logic       w;
  } vec_t;
  vec_t tbl[24];
  always #5 clk = ~clk;
  decoder_scan_param #(.N(2), .DW(8), .ONESHOT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .a(a2), .dwell(dwell),
    .y(y2), .valid(v2), .wrap(w2));
  decoder_scan_param #(.N(3), .DW(8), .ONESHOT(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .a(a3), .dwell(dwell),
    .y(y3), .valid(v3), .wrap(w3));
  decoder_scan_param #(.N(2), .DW(8), .ONESHOT(1)) dut_os (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .a(a2), .dwell(dwell),
    .y(yo), .valid(vo), .wrap(wo));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic chk2(input string nm, input logic [3:0] ey, input logic ev, input logic ew);
    chk({nm, ".y"}, 32'(y2), 32'(ey));
    chk({nm, ".valid"}, 32'(v2), 32'(ev));
    chk({nm, ".wrap"}, 32'(w2), 32'(ew));
  endtask
  task automatic chko(input string nm, input logic [3:0] ey, input logic ev, input logic ew);
    chk({nm, ".y"}, 32'(yo), 32'(ey));
    chk({nm, ".valid"}, 32'(vo), 32'(ev));
    chk({nm, ".wrap"}, 32'(wo), 32'(ew));
  endtask
  initial begin
    tbl[0]  = '{1'b1, MODE_ONEHOT, 2'd0, 8'd0, 4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, MODE_ONEHOT, 2'd1, 8'd0, 4'b0010, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, MODE_ONEHOT, 2'd2, 8'd0, 4'b0100, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, MODE_ONEHOT, 2'd3, 8'd0, 4'b1000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, MODE_ONEHOT, 2'd3, 8'd0, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, MODE_THERM,  2'd0, 8'd0, 4'b0001, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, MODE_THERM,  2'd2, 8'd0, 4'b0111, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, MODE_THERM,  2'd3, 8'd0, 4'b1111, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, MODE_SCAN,   2'd2, 8'd1, 4'b0100, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, MODE_SCAN,   2'd0, 8'd1, 4'b0100, 1'b1, 1'b0};
    tbl[10] = '{1'b1, MODE_SCAN,   2'd0, 8'd1, 4'b1000, 1'b1, 1'b0};
    tbl[11] = '{1'b1, MODE_SCAN,   2'd0, 8'd1, 4'b1000, 1'b1, 1'b0};
    tbl[12] = '{1'b1, MODE_SCAN,   2'd0, 8'd1, 4'b0001, 1'b1, 1'b1};
    tbl[13] = '{1'b1, MODE_SCAN,   2'd0, 8'd1, 4'b0001, 1'b1, 1'b0};
    tbl[14] = '{1'b1, MODE_SCAN,   2'd0, 8'd1, 4'b0010, 1'b1, 1'b0};
    tbl[15] = '{1'b1, MODE_SCAN,   2'd0, 8'd0, 4'b0100, 1'b1, 1'b0};
    tbl[16] = '{1'b1, MODE_SCAN,   2'd0, 8'd0, 4'b1000, 1'b1, 1'b0};
    tbl[17] = '{1'b1, MODE_SCAN,   2'd0, 8'd0, 4'b0001, 1'b1, 1'b1};
    tbl[18] = '{1'b1, MODE_SCAN,   2'd0, 8'd0, 4'b0010, 1'b1, 1'b0};
    tbl[19] = '{1'b1, MODE_ONEHOT, 2'd0, 8'd0, 4'b0001, 1'b1, 1'b0};
    tbl[20] = '{1'b1, MODE_HOLD,   2'd0, 8'd0, 4'b0001, 1'b1, 1'b0};
    tbl[21] = '{1'b1, MODE_SCAN,   2'd1, 8'd0, 4'b0010, 1'b1, 1'b0};
    tbl[22] = '{1'b0, MODE_THERM,  2'd3, 8'd0, 4'b0000, 1'b0, 1'b0};
    tbl[23] = '{1'b1, MODE_HOLD,   2'd0, 8'd0, 4'b0000, 1'b0, 1'b0};
    #2 rst_n = 1'b0;
    #1 chk2("reset", 4'b0000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      enable = tbl[i].en;
      mode   = tbl[i].mode;
      a2     = tbl[i].a;
      dwell  = tbl[i].dwell;
      tick();
      chk2($sformatf("row%0d", i), tbl[i].y, tbl[i].v, tbl[i].w);
    end
    // mid-scan hold: cnt=2 of dwell=3 is frozen, then one more count before the step
    enable = 1'b1; mode = MODE_SCAN; a2 = 2'd0; dwell = 8'd3;
    tick();
    tick();
    tick();
    chk2("prehold", 4'b0001, 1'b1, 1'b0);
    mode = MODE_HOLD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk2($sformatf("hold%0d", i), 4'b0001, 1'b1, 1'b0);
    end
    mode = MODE_SCAN; a2 = 2'd3;
    tick();
    chk2("resume", 4'b0001, 1'b1, 1'b0);
    tick();
    chk2("resume_step", 4'b0010, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1 chk2("async_rst", 4'b0000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    mode = MODE_THERM;
    for (int i = 0; i < 3; i++) begin
      a3 = (i == 0) ? 3'd0 : (i == 1) ? 3'd4 : 3'd7;
      tick();
      chk($sformatf("therm3_a%0d", a3), 32'(y3), (i == 0) ? 32'h01 : (i == 1) ? 32'h1f : 32'hff);
      chk("therm3.valid", 32'(v3), 32'd1);
    end
    mode = MODE_ONEHOT; a3 = 3'd5;
    tick();
    chk("onehot3_a5", 32'(y3), 32'h20);
    enable = 1'b0;
    tick();
    chk("dis3", 32'(y3), 32'h00);
    enable = 1'b1; mode = MODE_SCAN; a2 = 2'd3; dwell = 8'd0;
    tick();
    chko("os_entry", 4'b1000, 1'b1, 1'b0);
    tick();
    chko("os_end", 4'b0000, 1'b0, 1'b1);
    tick();
    chko("os_done1", 4'b0000, 1'b0, 1'b0);
    tick();
    chko("os_done2", 4'b0000, 1'b0, 1'b0);
    mode = MODE_HOLD;
    tick();
    chko("os_hold", 4'b0000, 1'b0, 1'b0);
    mode = MODE_SCAN; a2 = 2'd1;
    tick();
    chko("os_restart", 4'b0010, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
